// File: rtl/rob_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rob_pkg
// Desc     : Shared types and width constants for the rob_multi reorder buffer.
// Revision : 1.0 - initial release
// ============================================================================
package rob_pkg;

    // Entry field widths; rob_multi width parameters default to these.
    localparam int c_DATA_W = 32;
    localparam int c_AREG_W = 5;
    localparam int c_PREG_W = 6;

    typedef enum logic [0:0] {
        RUN = 1'b0,
        EXC = 1'b1
    } rob_state_e;

    typedef struct packed {
        logic                valid;
        logic                done;
        logic                exc;
        logic                wen;
        logic [c_AREG_W-1:0] areg;
        logic [c_PREG_W-1:0] preg;
        logic [c_PREG_W-1:0] old_preg;
        logic [c_DATA_W-1:0] data;
    } rob_entry_t;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rob_commit_sel.sv
`default_nettype none
// ============================================================================
// Module   : rob_commit_sel
// Desc     : Prefix-AND of head-relative ready bits into a contiguous commit
//            mask plus its population count.
// Revision : 1.0 - initial release
// ============================================================================
module rob_commit_sel #(
    parameter int COMMIT_W = 2,
    parameter int CNT_W    = 2
) (
    input  logic                i_en,
    input  logic [COMMIT_W-1:0] i_rdy,
    output logic [COMMIT_W-1:0] o_mask,
    output logic [CNT_W-1:0]    o_cnt
);

    logic w_run;

    always_comb begin
        w_run  = i_en;
        o_mask = '0;
        o_cnt  = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            w_run     = w_run & i_rdy[k];
            o_mask[k] = w_run;
            o_cnt     = o_cnt + CNT_W'(w_run);
        end
    end

endmodule
`default_nettype wire

// File: rtl/rob_multi.sv
`default_nettype none
// ============================================================================
// Module   : rob_multi
// Desc     : Parametrised reorder buffer: in-order alloc, multi-channel
//            out-of-order writeback, up to COMMIT_W in-order retirements/cycle.
// Config   : ROB_EXCEPTION_EN enables the precise-exception drain path.
// Revision : 1.0 - initial release
// ============================================================================
module rob_multi
    import rob_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int NUM_WB   = 4,
    parameter int COMMIT_W = 2,
    parameter int DATA_W   = c_DATA_W,
    parameter int AREG_W   = c_AREG_W,
    parameter int PREG_W   = c_PREG_W,
    parameter int IDX_W    = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    input  logic                       alloc_wen,
    input  logic [AREG_W-1:0]          alloc_areg,
    input  logic [PREG_W-1:0]          alloc_preg,
    input  logic [PREG_W-1:0]          alloc_old_preg,
    output logic [IDX_W-1:0]           alloc_idx,
    input  logic [NUM_WB-1:0]          wb_valid,
    input  logic [NUM_WB*IDX_W-1:0]    wb_idx,
    input  logic [NUM_WB*DATA_W-1:0]   wb_data,
    input  logic [NUM_WB-1:0]          wb_exc,
    input  logic                       cm_ready,
    output logic [COMMIT_W-1:0]        cm_valid,
    output logic [COMMIT_W-1:0]        cm_wen,
    output logic [COMMIT_W*AREG_W-1:0] cm_areg,
    output logic [COMMIT_W*PREG_W-1:0] cm_preg,
    output logic [COMMIT_W*PREG_W-1:0] cm_old_preg,
    output logic [COMMIT_W*DATA_W-1:0] cm_data,
    input  logic                       flush,
    output logic                       exc_flush,
    output logic [IDX_W-1:0]           exc_idx,
    output logic [IDX_W:0]             count,
    output logic                       empty,
    output logic                       full
);

    localparam int c_CNT_W = cnt_w(COMMIT_W);

    rob_entry_t          r_ent [DEPTH];
    rob_entry_t          w_slot [COMMIT_W];
    rob_state_e          r_state;
    rob_state_e          w_state_nxt;
    logic [IDX_W-1:0]    r_head;
    logic [IDX_W-1:0]    r_tail;
    logic [IDX_W:0]      r_count;
    logic [IDX_W-1:0]    w_wb_idx [NUM_WB];
    logic [COMMIT_W-1:0] w_rdy;
    logic [COMMIT_W-1:0] w_mask;
    logic [c_CNT_W-1:0]  w_ncm;
    logic                w_alloc;
    logic                w_cm_en;
    logic                w_head_exc;
    logic                w_clear;

    assign full        = (r_count == (IDX_W+1)'(DEPTH));
    assign empty       = (r_count == '0);
    assign count       = r_count;
    assign alloc_idx   = r_tail;
    assign alloc_ready = !full && (r_state == RUN) && !flush;
    assign w_alloc     = alloc_valid && alloc_ready;
    assign w_cm_en     = cm_ready && (r_state == RUN) && !flush;
    assign w_clear     = flush || (r_state == EXC);

    generate
        for (genvar ch = 0; ch < NUM_WB; ch++) begin : g_wb_idx
            assign w_wb_idx[ch] = wb_idx[ch*IDX_W +: IDX_W];
        end

        // Slot k looks at (head+k) mod DEPTH; the add wraps in IDX_W bits.
        for (genvar k = 0; k < COMMIT_W; k++) begin : g_slot
            assign w_slot[k] = r_ent[r_head + IDX_W'(k)];
            assign w_rdy[k]  = w_slot[k].valid && w_slot[k].done && !w_slot[k].exc
                               && ((IDX_W+1)'(k) < r_count);
            assign cm_valid[k] = w_mask[k];
            assign cm_wen[k]   = w_mask[k] & w_slot[k].wen;
            assign cm_areg[k*AREG_W +: AREG_W]     = w_mask[k] ? AREG_W'(w_slot[k].areg) : '0;
            assign cm_preg[k*PREG_W +: PREG_W]     = w_mask[k] ? PREG_W'(w_slot[k].preg) : '0;
            assign cm_old_preg[k*PREG_W +: PREG_W] = w_mask[k] ? PREG_W'(w_slot[k].old_preg) : '0;
            assign cm_data[k*DATA_W +: DATA_W]     = w_mask[k] ? DATA_W'(w_slot[k].data) : '0;
        end
    endgenerate

    rob_commit_sel #(
        .COMMIT_W (COMMIT_W),
        .CNT_W    (c_CNT_W)
    ) u_commit_sel (
        .i_en   (w_cm_en),
        .i_rdy  (w_rdy),
        .o_mask (w_mask),
        .o_cnt  (w_ncm)
    );

`ifdef ROB_EXCEPTION_EN
    assign w_head_exc = w_slot[0].valid && w_slot[0].done && w_slot[0].exc;
    assign exc_flush  = (r_state == EXC);
    assign exc_idx    = (r_state == EXC) ? r_head : '0;
`else
    logic w_unused_exc;
    assign w_unused_exc = |wb_exc;
    assign w_head_exc   = 1'b0;
    assign exc_flush    = 1'b0;
    assign exc_idx      = '0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = RUN;
        end else begin
            case (r_state)
                RUN:     if (w_head_exc) w_state_nxt = EXC;
                EXC:     w_state_nxt = RUN;
                default: w_state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= RUN;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i].valid <= 1'b0;
                r_ent[i].done  <= 1'b0;
                r_ent[i].exc   <= 1'b0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            // Ascending loop: the highest channel hitting a tag wins.
            for (int ch = 0; ch < NUM_WB; ch++) begin
                if (wb_valid[ch] && r_ent[w_wb_idx[ch]].valid) begin
                    r_ent[w_wb_idx[ch]].done <= 1'b1;
                    r_ent[w_wb_idx[ch]].data <= c_DATA_W'(wb_data[ch*DATA_W +: DATA_W]);
`ifdef ROB_EXCEPTION_EN
                    r_ent[w_wb_idx[ch]].exc  <= wb_exc[ch];
`else
                    r_ent[w_wb_idx[ch]].exc  <= 1'b0;
`endif
                end
            end
            for (int k = 0; k < COMMIT_W; k++) begin
                if (w_mask[k]) begin
                    r_ent[r_head + IDX_W'(k)].valid <= 1'b0;
                    r_ent[r_head + IDX_W'(k)].done  <= 1'b0;
                    r_ent[r_head + IDX_W'(k)].exc   <= 1'b0;
                end
            end
            if (w_alloc) begin
                r_ent[r_tail] <= '{valid: 1'b1, done: 1'b0, exc: 1'b0, wen: alloc_wen,
                                   areg: c_AREG_W'(alloc_areg),
                                   preg: c_PREG_W'(alloc_preg),
                                   old_preg: c_PREG_W'(alloc_old_preg),
                                   data: '0};
            end
            r_head  <= r_head + IDX_W'(w_ncm);
            r_tail  <= r_tail + IDX_W'(w_alloc);
            r_count <= r_count + (IDX_W+1)'(w_alloc) - (IDX_W+1)'(w_ncm);
        end
    end

`ifndef SYNTHESIS
    logic w_wb_dup;
    always_comb begin
        w_wb_dup = 1'b0;
        for (int i = 0; i < NUM_WB; i++) begin
            for (int j = i + 1; j < NUM_WB; j++) begin
                if (wb_valid[i] && wb_valid[j] && (w_wb_idx[i] == w_wb_idx[j])) w_wb_dup = 1'b1;
            end
        end
    end

    a_wb_tag_unique: assert property (@(posedge clk) disable iff (!rst_n) !w_wb_dup);
`endif

endmodule
`default_nettype wire

// File: doc/rob_multi.md
# rob_multi

Parametrised reorder buffer, successor to the fixed four-channel ROB. Takes in-order allocation of one instruction per cycle from rename, accepts out-of-order completion on `NUM_WB` writeback channels, and retires up to `COMMIT_W` entries per cycle in program order. Retirement broadcasts architectural/physical register info to the register manager. An optional precise-exception path drains and clears the buffer.

## Interface
- `DEPTH`, 16, entry count; power of two, ≥4.
- `NUM_WB`, 4, writeback channels.
- `COMMIT_W`, 2, max retirements per cycle (1..4).
- `DATA_W`, 32, result width.
- `AREG_W`, 5, architectural register index width.
- `PREG_W`, 6, physical register index width.
- `IDX_W`, $clog2(DEPTH), derived entry-tag width.

Ports:
- `clk` in 1: clock. One clock only.
- `rst_n` in 1: asynchronous, active-low reset.
- `alloc_valid` in 1: rename offers an instruction.
- `alloc_ready` out 1: entry available.
- `alloc_wen` in 1: instruction writes a register.
- `alloc_areg` in AREG_W: destination register.
- `alloc_preg` in PREG_W: newly allocated physical register.
- `alloc_old_preg` in PREG_W: previous mapping, freed on commit.
- `alloc_idx` out IDX_W: tag assigned; valid while `alloc_valid & alloc_ready`.
- `wb_valid` in NUM_WB: per-channel completion.
- `wb_idx` in NUM_WB*IDX_W: tag per channel.
- `wb_data` in NUM_WB*DATA_W: result per channel.
- `wb_exc` in NUM_WB: exception flag per channel.
- `cm_ready` in 1: commit consumer accepts this cycle.
- `cm_valid` out COMMIT_W: slot k retires; contiguous from bit 0.
- `cm_wen`, `cm_areg`, `cm_preg`, `cm_old_preg`, `cm_data` out COMMIT_W × (1, AREG_W, PREG_W, PREG_W, DATA_W): retired entry fields, slot 0 oldest.
- `flush` in 1: external full flush (mispredict).
- `exc_flush` out 1: exception flush pulse (macro-gated).
- `exc_idx` out IDX_W: tag of the faulting entry (macro-gated).
- `count` out IDX_W+1; `empty` out 1; `full` out 1.

## Operation
- Circular buffer, `head`/`tail` pointers mod DEPTH, plus a `count` register. Entry holds valid, done, exc, wen, areg, preg, old_preg, data.
- Allocate when `alloc_valid & alloc_ready`: write entry at `tail`, done=0, tail+1, count+1. `alloc_idx = tail`.
- `alloc_ready = !full & state==RUN & !flush`. It does not depend on same-cycle commit.
- Writeback on channel i: if entry `wb_idx[i]` is valid, set done=1 and store data and exc. Writeback to an invalid entry is ignored. If two channels hit the same tag, the higher channel wins; this is an illegal case and the simulation assertion fires.
- Commit selection: slot k is valid iff `cm_ready`, `state==RUN`, `!flush`, entries head..head+k are all valid & done & !exc, and k < count. Head advances by popcount(`cm_valid`), entries are cleared, and count is reduced.
- Simultaneous alloc and commit: count += 1 − n.
- FSM states RUN and EXC (macro-gated):
  - RUN→EXC when the head is valid & done & exc; no commits that cycle.
  - In EXC, `exc_flush` is high for exactly one cycle with `exc_idx = head`. All entries are cleared, head=tail=count=0, and the FSM returns to RUN.
- External `flush`: all valid bits are cleared, head=tail=count=0 next cycle. Same-cycle alloc, writeback and commit are dropped. `flush` has priority over EXC, and the FSM goes to RUN.
- Reset mid-operation: the same clearing as flush, asynchronous.

## Timing
- Reset values: `alloc_ready`=1, `empty`=1, and all other outputs 0. FSM=RUN.
- Allocate at cycle t. The earliest legal writeback is t+1. Done is visible at t+2, and the earliest commit is at t+2.
- Commit outputs are combinational from registered state and `cm_ready`/`flush`. No other input-to-output combinational path exists except `alloc_idx`/`alloc_ready`.
- Full: count==DEPTH, so `alloc_ready`=0. The first free slot reappears the cycle after a commit.
- Wrap-around: pointers wrap DEPTH−1→0. Commit slots index (head+k) mod DEPTH.

## Configuration
- `ROB_EXCEPTION_EN` defined: the exc bit is stored, and the EXC state, `exc_flush` and `exc_idx` are active as above.
- `ROB_EXCEPTION_EN` undefined: `wb_exc` is ignored, no exc storage and no EXC state; `exc_flush` and `exc_idx` are tied to 0.

## Structure
- Package `rob_pkg`: `rob_entry_t` struct, `rob_state_e` enum (RUN, EXC), and width helper constants.
- Sub-module `rob_commit_sel`: prefix-AND of head-relative ready bits, producing the contiguous `cm_valid` mask and its popcount.

## Test plan
- Basic retirement: allocate 3 entries (tags 0,1,2), writeback 2, then 0, then 1 → tag 0 retires alone; next cycle tags 1 and 2 retire together (`cm_valid`=2'b11).
- Full and wrap-around: with DEPTH=16, fill 16 → `full`=1 and `alloc_ready`=0. Complete and commit 2, then allocate 2 → tags 0 and 1 are reused, count=16.
- Commit stall: all entries done, `cm_ready`=0 for 3 cycles → no retirement and head unchanged. On release, 2 retire per cycle.
- Exception: macro on, tag 1 completes with exc, tag 0 is clean → tag 0 retires. Next cycle no commit; the following cycle `exc_flush`=1 and `exc_idx`=1; afterwards count=0 and `empty`=1.
- Flush race: `flush` asserted in the same cycle as an alloc, a writeback and a potential commit → `cm_valid`=0, the alloc is dropped, count=0 next cycle.
- Async reset: assert `rst_n` low mid-burst → outputs immediately take their reset values, with no clock edge needed.
